lbp: RTL and testbench



---
 rtl/lbp_pkg.sv | 23 ++
 rtl/lbp_compare.sv | 22 ++
 rtl/lbp.sv | 194 +++++++++++++++++++
 tb/tb_lbp.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared types and helpers for the LBP engine: state encoding, 3x3 window, pixel addressing.
package lbp_pkg;

  localparam int unsigned IMG_W = 128;
  localparam int unsigned AW    = 14;

  typedef enum logic [2:0] {
    IDLE,
    BORDER,
    FETCH,
    WRITE,
    DONE
  } state_t;

  // Neighbourhood window indexed [row][col], row 0 = top, col 0 = left.
  typedef logic [2:0][2:0][7:0] win_t;

  function automatic int unsigned pix_addr(input int unsigned row, input int unsigned col,
                                           input int unsigned width);
    return row * width + col;
  endfunction

endpackage

// File: rtl/lbp_compare.sv
// Combinational LBP code: each neighbour >= centre sets its bit (ties count as 1).
module lbp_compare
  import lbp_pkg::*;
(
  input  win_t       i_win,
  output logic [7:0] o_code_c
);

  logic [7:0] w_ctr;

  assign w_ctr = i_win[1][1];

  assign o_code_c = {i_win[2][2] >= w_ctr,   // bottom-right
                     i_win[2][1] >= w_ctr,   // bottom
                     i_win[2][0] >= w_ctr,   // bottom-left
                     i_win[1][2] >= w_ctr,   // right
                     i_win[1][0] >= w_ctr,   // left
                     i_win[0][2] >= w_ctr,   // top-right
                     i_win[0][1] >= w_ctr,   // top
                     i_win[0][0] >= w_ctr};  // top-left

endmodule

// File: rtl/lbp.sv
// LBP engine: raster walk over interior pixels, 3x3 window fetch, one result write per pixel.
// Optional border zero-writes before interior processing when LBP_BORDER_WRITE_EN is defined.
module lbp #(
  parameter int unsigned IMG_W = lbp_pkg::IMG_W,
  parameter int unsigned AW    = lbp_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [7:0]    gray_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);
  import lbp_pkg::*;

  localparam int unsigned CW   = $clog2(IMG_W);
  localparam int unsigned NPIX = IMG_W * IMG_W;
  localparam logic [CW-1:0] LAST = CW'(IMG_W - 2);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_row, r_col, w_row_nxt, w_col_nxt;
  logic [1:0]    r_frow, r_fcol, w_frow_nxt, w_fcol_nxt;
  win_t          r_win, w_win_nxt;
  logic [7:0]    w_code;

  logic          r_gray_req, w_req_nxt;
  logic [AW-1:0] r_gray_addr, w_gaddr_nxt;
  logic          r_lbp_valid, w_valid_nxt;
  logic [AW-1:0] r_lbp_addr, w_laddr_nxt;
  logic [7:0]    r_lbp_data, w_ldata_nxt;
  logic          r_finish, w_finish_nxt;

`ifdef LBP_BORDER_WRITE_EN
  logic [AW-1:0] r_baddr, w_baddr_nxt;

  function automatic logic is_border(input logic [AW-1:0] a);
    int unsigned row, col;
    row = 32'(a) / IMG_W;
    col = 32'(a) % IMG_W;
    return (row == 0) || (col == 0) || (row == IMG_W - 1) || (col == IMG_W - 1);
  endfunction
`endif

  lbp_compare u_compare (
    .i_win    (w_win_nxt),
    .o_code_c (w_code)
  );

  // Window update: capture the fetched pixel, or slide one column left after a write.
  always_comb begin
    w_win_nxt = r_win;
    if (r_state == FETCH) begin
      w_win_nxt[r_frow][r_fcol] = gray_data;
    end else if (r_state == WRITE) begin
      for (int i = 0; i < 3; i++) begin
        w_win_nxt[i][0] = r_win[i][1];
        w_win_nxt[i][1] = r_win[i][2];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_row_nxt    = r_row;
    w_col_nxt    = r_col;
    w_frow_nxt   = r_frow;
    w_fcol_nxt   = r_fcol;
    w_req_nxt    = 1'b0;
    w_gaddr_nxt  = r_gray_addr;
    w_valid_nxt  = 1'b0;
    w_laddr_nxt  = r_lbp_addr;
    w_ldata_nxt  = r_lbp_data;
    w_finish_nxt = 1'b0;
`ifdef LBP_BORDER_WRITE_EN
    w_baddr_nxt  = r_baddr;
`endif
    case (r_state)
      IDLE: begin
        if (gray_ready) begin
`ifdef LBP_BORDER_WRITE_EN
          w_state_nxt = BORDER;
          w_baddr_nxt = '0;
          w_valid_nxt = 1'b1;
          w_laddr_nxt = '0;
          w_ldata_nxt = '0;
`else
          w_state_nxt = FETCH;
`endif
        end
      end
`ifdef LBP_BORDER_WRITE_EN
      BORDER: begin
        if (r_baddr == AW'(NPIX - 1)) begin
          w_state_nxt = FETCH;
        end else begin
          w_baddr_nxt = r_baddr + AW'(1);
          w_valid_nxt = is_border(w_baddr_nxt);
          w_laddr_nxt = w_baddr_nxt;
          w_ldata_nxt = '0;
        end
      end
`endif
      FETCH: begin
        if (r_frow == 2'd2) begin
          w_frow_nxt = '0;
          if (r_fcol == 2'd2) begin
            w_state_nxt = WRITE;
            w_valid_nxt = 1'b1;
            w_laddr_nxt = AW'(pix_addr(32'(r_row), 32'(r_col), IMG_W));
            w_ldata_nxt = w_code;
          end else begin
            w_fcol_nxt = r_fcol + 2'd1;
          end
        end else begin
          w_frow_nxt = r_frow + 2'd1;
        end
      end
      WRITE: begin
        if (r_col == LAST) begin
          if (r_row == LAST) begin
            w_state_nxt  = DONE;
            w_finish_nxt = 1'b1;
          end else begin
            w_state_nxt = FETCH;
            w_row_nxt   = r_row + CW'(1);
            w_col_nxt   = CW'(1);
            w_fcol_nxt  = 2'd0;
          end
        end else begin
          // Window already holds columns c and c+1 after the shift; only the new right column is read.
          w_state_nxt = FETCH;
          w_col_nxt   = r_col + CW'(1);
          w_fcol_nxt  = 2'd2;
        end
      end
      DONE: w_finish_nxt = 1'b1;
      default: w_state_nxt = IDLE;
    endcase

    if (w_state_nxt == FETCH) begin
      w_req_nxt   = 1'b1;
      w_gaddr_nxt = AW'(pix_addr(32'(w_row_nxt) + 32'(w_frow_nxt) - 32'd1,
                                 32'(w_col_nxt) + 32'(w_fcol_nxt) - 32'd1, IMG_W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_row       <= CW'(1);
      r_col       <= CW'(1);
      r_frow      <= '0;
      r_fcol      <= '0;
      r_win       <= '0;
      r_gray_req  <= 1'b0;
      r_gray_addr <= '0;
      r_lbp_valid <= 1'b0;
      r_lbp_addr  <= '0;
      r_lbp_data  <= '0;
      r_finish    <= 1'b0;
`ifdef LBP_BORDER_WRITE_EN
      r_baddr     <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_col       <= w_col_nxt;
      r_frow      <= w_frow_nxt;
      r_fcol      <= w_fcol_nxt;
      r_win       <= w_win_nxt;
      r_gray_req  <= w_req_nxt;
      r_gray_addr <= w_gaddr_nxt;
      r_lbp_valid <= w_valid_nxt;
      r_lbp_addr  <= w_laddr_nxt;
      r_lbp_data  <= w_ldata_nxt;
      r_finish    <= w_finish_nxt;
`ifdef LBP_BORDER_WRITE_EN
      r_baddr     <= w_baddr_nxt;
`endif
    end
  end

  assign gray_req  = r_gray_req;
  assign gray_addr = r_gray_addr;
  assign lbp_valid = r_lbp_valid;
  assign lbp_addr  = r_lbp_addr;
  assign lbp_data  = r_lbp_data;
  assign finish    = r_finish;

endmodule

// File: tb/tb_lbp.sv
// Self-checking bench for lbp on a reduced 16x16 image; reference LBP computed from the image array.
module tb_lbp;

  localparam int unsigned W        = 16;
  localparam int unsigned AWT      = 8;
  localparam int unsigned NPIX     = W * W;
  localparam int unsigned INTERIOR = (W - 2) * (10 + (W - 3) * 4);
`ifdef LBP_BORDER_WRITE_EN
  localparam int unsigned PRE      = NPIX;
  localparam int unsigned NBORDER  = 4 * W - 4;
`else
  localparam int unsigned PRE      = 0;
  localparam int unsigned NBORDER  = 0;
`endif
  localparam int unsigned LIMIT    = PRE + INTERIOR + 200;

  logic           clk = 1'b0;
  logic           reset;
  logic           gray_ready;
  logic           gray_req;
  logic [AWT-1:0] gray_addr;
  logic [7:0]     gray_data;
  logic           lbp_valid;
  logic [AWT-1:0] lbp_addr;
  logic [7:0]     lbp_data;
  logic           finish;

  always #5 clk = ~clk;

  lbp #(.IMG_W(W), .AW(AWT)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish)
  );

  logic [7:0] img     [NPIX];
  logic [7:0] res     [NPIX];
  logic [7:0] exp_res [NPIX];
  int dr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
  int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

  int checks = 0;
  int errors = 0;
  int n_border_wr, n_border_bad, n_interior_wr, n_order_bad;
  bit seen_interior;

  // Source ROM answers mid-cycle; result RAM samples at the falling edge.
  always @(negedge clk) gray_data = gray_req ? img[gray_addr] : 8'bz;

  always @(negedge clk) begin
    int a, r, c, er, ec;
    if (!reset && lbp_valid) begin
      a = int'(lbp_addr);
      r = a / W;
      c = a % W;
      if (r == 0 || c == 0 || r == W - 1 || c == W - 1) begin
        n_border_wr++;
        if (lbp_data != 8'd0 || seen_interior) n_border_bad++;
      end else begin
        er = n_interior_wr / (W - 2) + 1;
        ec = n_interior_wr % (W - 2) + 1;
        if (r != er || c != ec) n_order_bad++;
        n_interior_wr++;
        seen_interior = 1'b1;
      end
      res[lbp_addr] = lbp_data;
    end
  end

  function automatic void build_expected();
    logic [7:0] code;
    for (int a = 0; a < NPIX; a++) exp_res[a] = 8'd0;
    for (int r = 1; r < W - 1; r++)
      for (int c = 1; c < W - 1; c++) begin
        code = 8'd0;
        for (int k = 0; k < 8; k++)
          code[k] = (img[(r + dr[k]) * W + c + dc[k]] >= img[r * W + c]);
        exp_res[r * W + c] = code;
      end
  endfunction

  function automatic int count_mismatches(output int first);
    int n = 0;
    first = -1;
    for (int a = 0; a < NPIX; a++)
      if (res[a] !== exp_res[a]) begin
        if (n == 0) first = a;
        n++;
      end
    return n;
  endfunction

  task automatic clear_run();
    for (int a = 0; a < NPIX; a++) res[a] = 8'd0;
    n_border_wr = 0; n_border_bad = 0; n_interior_wr = 0; n_order_bad = 0;
    seen_interior = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    gray_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Raises gray_ready after ready_delay cycles; counts cycles from the first edge that sees it.
  task automatic run_image(input int ready_delay, output int cycles, output int req_early);
    req_early = 0;
    repeat (ready_delay) begin
      @(posedge clk); #1;
      if (gray_req) req_early++;
    end
    @(negedge clk);
    gray_ready = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!finish && cycles < LIMIT);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gray_req !== 1'b0) begin errors++; $display("FAIL reset_gray_req got %b want 0", gray_req); end
    checks++; if (gray_addr !== '0) begin errors++; $display("FAIL reset_gray_addr got %h want 0", gray_addr); end
    checks++; if (lbp_valid !== 1'b0) begin errors++; $display("FAIL reset_lbp_valid got %b want 0", lbp_valid); end
    checks++; if (lbp_addr !== '0) begin errors++; $display("FAIL reset_lbp_addr got %h want 0", lbp_addr); end
    checks++; if (lbp_data !== 8'd0) begin errors++; $display("FAIL reset_lbp_data got %h want 0", lbp_data); end
    checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b want 0", finish); end
  endtask

  task automatic test_const_image();
    int cyc, early, mism, first;
    for (int a = 0; a < NPIX; a++) img[a] = 8'h80;
    build_expected();
    clear_run();
    do_reset();
    run_image(0, cyc, early);
    checks++; if (cyc != int'(PRE + INTERIOR + 1)) begin errors++; $display("FAIL const_cycles got %0d want %0d", cyc, PRE + INTERIOR + 1); end
    mism = count_mismatches(first);
    checks++; if (mism != 0) begin errors++; $display("FAIL const_image %0d bad addrs, first %0d got %h want %h", mism, first, res[first], exp_res[first]); end
    checks++; if (res[W + 1] !== 8'hFF) begin errors++; $display("FAIL const_code got %h want ff", res[W + 1]); end
    checks++; if (n_interior_wr != int'((W - 2) * (W - 2))) begin errors++; $display("FAIL const_writes got %0d want %0d", n_interior_wr, (W - 2) * (W - 2)); end
    checks++; if (n_order_bad != 0) begin errors++; $display("FAIL const_raster_order got %0d out-of-order want 0", n_order_bad); end
    checks++; if (n_border_wr != int'(NBORDER) || n_border_bad != 0) begin errors++; $display("FAIL border_writes got %0d (bad %0d) want %0d (bad 0)", n_border_wr, n_border_bad, NBORDER); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (finish !== 1'b1 || gray_req !== 1'b0 || lbp_valid !== 1'b0) begin errors++; $display("FAIL done_hold got finish=%b req=%b valid=%b want 1 0 0", finish, gray_req, lbp_valid); end
  endtask

  task automatic test_single_window();
    int cyc, early, mism, first;
    for (int a = 0; a < NPIX; a++) img[a] = 8'($urandom);
    img[0] = 8'd60;     img[1] = 8'd40;         img[2] = 8'd50;
    img[W] = 8'd10;     img[W + 1] = 8'd50;     img[W + 2] = 8'd90;
    img[2 * W] = 8'd50; img[2 * W + 1] = 8'd20; img[2 * W + 2] = 8'd70;
    build_expected();
    clear_run();
    do_reset();
    run_image(0, cyc, early);
    checks++; if (res[W + 1] !== 8'hB5) begin errors++; $display("FAIL window_code got %h want b5", res[W + 1]); end
    mism = count_mismatches(first);
    checks++; if (mism != 0 || cyc >= int'(LIMIT)) begin errors++; $display("FAIL window_image %0d bad addrs, first %0d, cycles %0d", mism, first, cyc); end
  endtask

  task automatic test_ramp();
    int cyc, early, mism, first;
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) img[r * W + c] = 8'(c);
    build_expected();
    clear_run();
    do_reset();
    run_image(0, cyc, early);
    // Same-column neighbours tie with the centre, so bits 1 and 6 join 2, 4 and 7.
    checks++; if (res[(W / 2) * W + W / 2] !== 8'hD6) begin errors++; $display("FAIL ramp_code got %h want d6", res[(W / 2) * W + W / 2]); end
    mism = count_mismatches(first);
    checks++; if (mism != 0) begin errors++; $display("FAIL ramp_image %0d bad addrs, first %0d got %h want %h", mism, first, res[first], exp_res[first]); end
  endtask

  task automatic test_random_ties();
    int cyc, early, mism, first;
    for (int a = 0; a < NPIX; a++) img[a] = 8'($urandom_range(0, 3));
    build_expected();
    clear_run();
    do_reset();
    run_image(0, cyc, early);
    mism = count_mismatches(first);
    checks++; if (mism != 0) begin errors++; $display("FAIL ties_image %0d bad addrs, first %0d got %h want %h", mism, first, res[first], exp_res[first]); end
  endtask

  task automatic test_delayed_ready();
    int cyc, early, mism, first;
    for (int a = 0; a < NPIX; a++) img[a] = 8'($urandom);
    build_expected();
    clear_run();
    do_reset();
    run_image(20, cyc, early);
    checks++; if (early != 0) begin errors++; $display("FAIL delayed_req got %0d request cycles before ready want 0", early); end
    checks++; if (cyc != int'(PRE + INTERIOR + 1)) begin errors++; $display("FAIL delayed_cycles got %0d want %0d", cyc, PRE + INTERIOR + 1); end
    mism = count_mismatches(first);
    checks++; if (mism != 0) begin errors++; $display("FAIL delayed_image %0d bad addrs, first %0d got %h want %h", mism, first, res[first], exp_res[first]); end
  endtask

  task automatic test_reset_mid();
    int cyc, early, mism, first;
    for (int a = 0; a < NPIX; a++) img[a] = 8'($urandom);
    build_expected();
    clear_run();
    do_reset();
    @(negedge clk);
    gray_ready = 1'b1;
    repeat (PRE + INTERIOR / 2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    gray_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if ({gray_req, lbp_valid, finish} !== 3'b000 || gray_addr !== '0 || lbp_addr !== '0 || lbp_data !== 8'd0) begin
      errors++; $display("FAIL midreset_outputs got req=%b addr=%h valid=%b laddr=%h data=%h fin=%b want all 0", gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_run();
    run_image(3, cyc, early);
    checks++; if (cyc != int'(PRE + INTERIOR + 1) || early != 0) begin errors++; $display("FAIL midreset_rerun got cycles %0d early req %0d want %0d and 0", cyc, early, PRE + INTERIOR + 1); end
    mism = count_mismatches(first);
    checks++; if (mism != 0) begin errors++; $display("FAIL midreset_image %0d bad addrs, first %0d got %h want %h", mism, first, res[first], exp_res[first]); end
  endtask

  initial begin
    reset = 1'b1;
    gray_ready = 1'b0;
    test_reset();
    test_const_image();
    test_single_window();
    test_ramp();
    test_random_ties();
    test_delayed_ready();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
